// File: rtl/matmul_pkg.sv
// matmul_pkg : shared types and defaults for the matmul result path (rev 1.0)
`default_nettype none

package matmul_pkg;
  localparam int RES_W       = 18;
  localparam int DEF_NUM_RES = 9;
  localparam int DEF_ADDR_W  = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    SEND = 3'd3,
    CLR  = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

`default_nettype wire

// File: rtl/res_reader_if.sv
// res_reader_if : result-store read port plus valid/ready output stream (rev 1.0)
`default_nettype none

interface res_reader_if
  import matmul_pkg::*;
#(
  parameter int DATA_W = RES_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic [ADDR_W-1:0] res_addr;
  logic              res_rd;
  logic [DATA_W-1:0] res_data;
  logic              clear_res;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output res_addr, res_rd, clear_res, out_data, out_valid,
    input  res_data, out_ready
  );

  modport slave (
    input  res_addr, res_rd, clear_res, out_data, out_valid,
    output res_data, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/res_reader.sv
// res_reader : drains NUM_RES result words in address order onto a valid/ready
// stream, then clears the store and pulses done (rev 1.0)
`default_nettype none

module res_reader
  import matmul_pkg::*;
#(
  parameter int DATA_W  = RES_W,
  parameter int NUM_RES = DEF_NUM_RES,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  res_reader_if.master     bus,
  output logic             busy,
  output logic             done
);
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_RES - 1);
  localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_state <= RD;
          end
        end
        RD:   r_state <= CAP;
        CAP: begin
          // store returns data one cycle after the RD strobe
          r_out_data  <= bus.res_data;
          r_out_valid <= 1'b1;
          r_state     <= SEND;
        end
        SEND: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_idx == c_LAST) begin
              r_state <= CLR;
            end else begin
              r_idx   <= r_idx + c_ONE;
              r_state <= RD;
            end
          end
        end
        CLR:     r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.res_addr  = r_idx;
  assign bus.res_rd    = (r_state == RD);
  assign bus.clear_res = (r_state == CLR);
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
endmodule

`default_nettype wire

// File: tb/tb_res_reader.sv
// tb_res_reader : directed checks of res_reader drain timing, stalls and reset (rev 1.0)
`default_nettype none
`timescale 1ns/1ps

module tb_res_reader;
  import matmul_pkg::*;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic start  = 1'b0;
  logic start1 = 1'b0;
  logic busy, done, busy1, done1;

  always #5 clk = ~clk;

  res_reader_if #(.DATA_W(18), .ADDR_W(4)) bus  ();
  res_reader_if #(.DATA_W(18), .ADDR_W(4)) bus1 ();

  res_reader #(.DATA_W(18), .NUM_RES(9), .ADDR_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
  );

  res_reader #(.DATA_W(18), .NUM_RES(1), .ADDR_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1), .busy(busy1), .done(done1)
  );

  // result-store model: one-cycle read latency, cleared by clear_res
  logic [17:0] mem [16];
  logic [17:0] pre [16];
  logic        do_load = 1'b0;

  always @(posedge clk) begin
    if (do_load) mem <= pre;
    else if (bus.clear_res) for (int i = 0; i < 16; i++) mem[i] <= '0;
    if (bus.res_rd) bus.res_data <= mem[bus.res_addr];
  end

  always @(posedge clk) if (bus1.res_rd) bus1.res_data <= 18'h2A5A5;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [17:0] beats[$];
  int          beat_cyc[$];
  int          n_clr, clr_cyc, n_done, done_cyc, viol;
  logic        busy_hist[64];
  logic [3:0]  addr_hist[64];

  task automatic load(input logic [17:0] base_val, input logic [17:0] last_val, input logic [17:0] first_val);
    for (int i = 0; i < 16; i++) pre[i] = base_val + 18'(i);
    pre[0] = first_val;
    pre[8] = last_val;
    do_load = 1'b1;
    @(posedge clk); #1;
    do_load = 1'b0;
  endtask

  // pulses start across edge 0 and returns at the start of cycle 1
  task automatic kick();
    beats.delete();
    beat_cyc.delete();
    n_clr = 0; clr_cyc = -1; n_done = 0; done_cyc = -1; viol = 0;
    for (int i = 0; i < 64; i++) begin busy_hist[i] = 1'bx; addr_hist[i] = 4'hx; end
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_cycles(input int ncyc, input int stall_at, input int stall_len,
                            input logic [17:0] stall_exp, input int s1, input int s2);
    for (int c = 1; c <= ncyc; c++) begin
      bus.out_ready = !(c >= stall_at && c < stall_at + stall_len);
      start = (c == s1) || (c == s2);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        beats.push_back(bus.out_data);
        beat_cyc.push_back(c);
      end
      if (bus.res_rd && bus.out_valid) viol++;
      if (bus.clear_res) begin n_clr++; clr_cyc = c; end
      if (done) begin n_done++; done_cyc = c; end
      if (c < 64) begin busy_hist[c] = busy; addr_hist[c] = bus.res_addr; end
      if (c >= stall_at && c < stall_at + stall_len) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(stall_exp));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  function automatic logic [17:0] beat_at(input int k);
    return (k < beats.size()) ? beats[k] : 18'h3DEAD;
  endfunction

  function automatic int cyc_at(input int k);
    return (k < beat_cyc.size()) ? beat_cyc[k] : -1;
  endfunction

  initial begin
    bus.out_ready  = 1'b1;
    bus1.out_ready = 1'b1;

    // asynchronous reset, observed before any clock edge
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_res_rd",    32'(bus.res_rd),    32'd0);
    check("rst_clear",     32'(bus.clear_res), 32'd0);
    check("rst_addr",      32'(bus.res_addr),  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // basic drain with timing
    load(18'h00010, 18'h00018, 18'h00010);
    kick();
    run_cycles(31, -100, 0, 18'h0, -1, -1);
    check("basic_count", 32'(beats.size()), 32'd9);
    for (int k = 0; k < 9; k++) begin
      check("basic_data", 32'(beat_at(k)), 32'(18'h00010 + 18'(k)));
      check("basic_cyc",  32'(cyc_at(k)),  32'(3 + 3 * k));
    end
    check("basic_clr_cyc",  32'(clr_cyc),  32'd28);
    check("basic_clr_n",    32'(n_clr),    32'd1);
    check("basic_done_cyc", 32'(done_cyc), 32'd29);
    check("basic_done_n",   32'(n_done),   32'd1);
    check("basic_busy30",   32'(busy_hist[30]), 32'd0);
    check("basic_addr30",   32'(addr_hist[30]), 32'd8);
    check("basic_rd_cyc1",  32'(addr_hist[1]),  32'd0);
    check("basic_store_clr", 32'(mem[4]), 32'd0);

    // back-pressure: 5 stall cycles on beat 4 (valid from cycle 15)
    load(18'h00010, 18'h00018, 18'h00010);
    kick();
    run_cycles(36, 15, 5, 18'h00014, -1, -1);
    check("bp_count", 32'(beats.size()), 32'd9);
    for (int k = 0; k < 9; k++) check("bp_data", 32'(beat_at(k)), 32'(18'h00010 + 18'(k)));
    check("bp_cyc4",     32'(cyc_at(4)), 32'd20);
    check("bp_cyc5",     32'(cyc_at(5)), 32'd23);
    check("bp_clr_cyc",  32'(clr_cyc),   32'd33);
    check("bp_done_cyc", 32'(done_cyc),  32'd34);
    check("bp_no_rd_pending", 32'(viol), 32'd0);

    // extremes and ordering
    load(18'h15550, 18'h3FFFF, 18'h00000);
    kick();
    run_cycles(31, -100, 0, 18'h0, -1, -1);
    check("max_count", 32'(beats.size()), 32'd9);
    check("max_first", 32'(beat_at(0)), 32'h00000);
    check("max_mid",   32'(beat_at(5)), 32'h15555);
    check("max_last",  32'(beat_at(8)), 32'h3FFFF);

    // start ignored mid-drain and during DONE
    load(18'h00010, 18'h00018, 18'h00010);
    kick();
    run_cycles(33, -100, 0, 18'h0, 10, 29);
    check("ign_count",  32'(beats.size()), 32'd9);
    check("ign_done_n", 32'(n_done),       32'd1);
    check("ign_done_cyc", 32'(done_cyc),   32'd29);
    check("ign_busy30", 32'(busy_hist[30]), 32'd0);
    check("ign_busy32", 32'(busy_hist[32]), 32'd0);

    // reset during beat 3 SEND
    load(18'h00010, 18'h00018, 18'h00010);
    kick();
    run_cycles(12, 12, 1, 18'h00013, -1, -1);
    bus.out_ready = 1'b0;
    check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_valid", 32'(bus.out_valid), 32'd0);
    check("mid_busy",  32'(busy),          32'd0);
    check("mid_rd",    32'(bus.res_rd),    32'd0);
    check("mid_clear", 32'(bus.clear_res), 32'd0);
    check("mid_addr",  32'(bus.res_addr),  32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mid_clear_hold", 32'(bus.clear_res), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_clr_n", 32'(n_clr), 32'd0);
    kick();
    run_cycles(31, -100, 0, 18'h0, -1, -1);
    check("mid_re_count", 32'(beats.size()), 32'd9);
    check("mid_re_first", 32'(beat_at(0)), 32'h00010);
    check("mid_re_last",  32'(beat_at(8)), 32'h00018);
    check("mid_re_done",  32'(done_cyc),   32'd29);

    // NUM_RES = 1 corner
    begin
      int b1_n, b1_cyc, c1_cyc, d1_cyc;
      logic [17:0] b1_data;
      b1_n = 0; b1_cyc = -1; c1_cyc = -1; d1_cyc = -1; b1_data = '0;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        if (bus1.out_valid && bus1.out_ready) begin b1_n++; b1_cyc = c; b1_data = bus1.out_data; end
        if (bus1.clear_res) c1_cyc = c;
        if (done1) d1_cyc = c;
        @(posedge clk); #1;
      end
      check("one_count", 32'(b1_n),    32'd1);
      check("one_beat",  32'(b1_cyc),  32'd3);
      check("one_data",  32'(b1_data), 32'h2A5A5);
      check("one_clr",   32'(c1_cyc),  32'd4);
      check("one_done",  32'(d1_cyc),  32'd5);
      check("one_idle",  32'(busy1),   32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire

// File: doc/res_reader.md
Name: res_reader

Overview:
- Drains the matrix-multiplication result store once a computation finishes.
- On start, reads NUM_RES 18-bit result entries in address order (0..NUM_RES-1) through a one-cycle-latency read port.
- Streams each entry out on a valid/ready interface.
- After the last beat is accepted, pulses clear_res to zero the store, then pulses done; this is the consumer end of the result-register write path.

Parameters:
- DATA_W, 18, result word width; matches result register width.
- NUM_RES, 9, entries per drain (3x3 product); legal range 1..2^ADDR_W.
- ADDR_W, 4, result-store address width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, begin a drain; sampled only in IDLE.
- res_addr, output, ADDR_W, result-store read address.
- res_rd, output, 1, read strobe to the result store.
- res_data, input, DATA_W, read data; valid the cycle after res_rd.
- clear_res, output, 1, one-cycle pulse that zeroes the result store.
- out_data, output, DATA_W, streamed result word.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts the beat when valid and ready are both high at a clock edge.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at drain completion.

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0, res_addr=0, res_rd=0, clear_res=0, out_data=0, out_valid=0, busy=0, done=0. All of these take effect immediately, not at the next edge.
- res_addr follows idx. res_rd, clear_res, busy and done are decodes of the registered state. out_data and out_valid are registers.
- States and transitions:
  - IDLE: start=1 -> RD, idx<=0. Otherwise hold.
  - RD: res_rd=1 for exactly one cycle at res_addr=idx -> CAP.
  - CAP: at the edge, out_data<=res_data and out_valid<=1 -> SEND.
  - SEND: hold out_data and out_valid stable while out_ready=0. On an edge with out_valid&out_ready: out_valid<=0.
    - If idx==NUM_RES-1 -> CLR.
    - Else idx<=idx+1 -> RD.
  - CLR: clear_res=1 for one cycle -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency with out_ready held high, start sampled at edge 0:
  - res_rd is high in cycle 1.
  - Beat k is valid in cycle 3+3k.
  - clear_res is high in cycle 3*NUM_RES+1; done in cycle 3*NUM_RES+2.
  - For NUM_RES=9: clear_res in cycle 28, done in cycle 29.
- Back-pressure: any number of out_ready=0 cycles stalls only in SEND. No beat is dropped, duplicated or altered, and no read is issued until the current beat is accepted.
- out_ready=1 while out_valid=0 has no effect.
- start outside IDLE, including during DONE, is ignored. No queuing.
- start held high continuously: a new drain begins on the first IDLE cycle after DONE.
- Wrap: idx never exceeds NUM_RES-1, and res_addr returns to 0 only on the next start.
- NUM_RES=1: single beat, then CLR, DONE.
- Reset mid-drain: the partial stream is abandoned and clear_res is not pulsed. The result store keeps its contents.
- Data is passed through unmodified; no arithmetic and no width conversion.

Decomposition:
- Shared package (matmul_pkg):
  - state encoding constants IDLE/RD/CAP/SEND/CLR/DONE, 3-bit;
  - RES_W=18;
  - default NUM_RES=9 and ADDR_W=4.
- No sub-module. The FSM, index counter and output register live in one module, about 150 lines.

Test Plan:
- Basic drain: store preloaded 0..8 with 18'h00010+i, out_ready=1, start pulse -> beats 18'h00010..18'h00018 in order at cycles 3,6,...,27. clear_res in cycle 28, done in cycle 29, busy low in cycle 30.
- Back-pressure: out_ready=0 for 5 cycles during beat 4 -> out_data=18'h00014 and out_valid hold stable across the stall. Exactly 9 beats are accepted and done is delayed by 5 cycles.
- Max value / ordering: entry 8 = 18'h3FFFF, entry 0 = 18'h00000 -> first beat 18'h00000, last beat 18'h3FFFF, no truncation.
- Start ignored: a second start pulse at cycle 10 and again during DONE -> exactly one drain of 9 beats and a single done pulse.
- Async reset mid-drain: rst=0 during beat 3 SEND -> out_valid, busy and res_rd drop immediately and clear_res stays 0. After rst=1 and a new start, beats restart from address 0.
- Parameter corner NUM_RES=1 -> one beat in cycle 3, clear_res in cycle 4, done in cycle 5.
